// File: rtl/async_to_sync_ctrl.sv
// Four-phase bundled-data receiver: synchronises async_req, captures async_d, offers it on valid/ready.
// Capture SYNC_STAGE edges after first sampling edge; async_ack is raised only after the consumer accepts.
module async_to_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGE = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  async_req,
    input  logic [DATA_WIDTH-1:0] async_d,
    output logic                  async_ack,
    output logic                  sync_valid,
    input  logic                  sync_ready,
    output logic [DATA_WIDTH-1:0] sync_d
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    logic req_s;

    generate
        if (SYNC_STAGE == 0) begin : g_nosync
            assign req_s = async_req;
        end else begin : g_sync
            logic [SYNC_STAGE-1:0] sync_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= async_req;
                    for (int i = 1; i < SYNC_STAGE; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign req_s = sync_q[SYNC_STAGE-1];
        end
    endgenerate

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // async_d needs no synchroniser: the sender holds it stable while req_s is high.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                ack_d   = 1'b0;
                valid_d = 1'b0;
                if (req_s) begin
                    data_d  = async_d;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (sync_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign async_ack  = ack_q;
    assign sync_valid = valid_q;
    assign sync_d     = data_q;

endmodule
